pwm_multichannel: RTL
=====================

// Module: pwm_multichannel
// PURPOSE
//  NUM_CH independent PWM channels, each with CNT_W-bit period/duty, edge- or centre-aligned output,
//  polarity, one-shot mode and glitch-free shadow updates at period boundaries. A global sync strobe
//  phase-aligns all counters. Sits behind the peripheral register decoder and drives the PWM pads.
// PARAMETERS
//  NUM_CH  4   number of channels (>=1)
//  CNT_W   16  counter/period/duty width in bits (>=4)
// PORTS
//  clk         in   1       system clock; all logic is rising-edge clk
//  rst         in   1       synchronous, active-high reset
//  wr_en       in   1       register write strobe, one write per cycle
//  wr_ch       in   CH_W    target channel; CH_W = max(1,$clog2(NUM_CH)); wr_ch>=NUM_CH -> write ignored
//  wr_sel      in   2       0=control 1=period 2=duty 3=reserved (ignored)
//  wr_data     in   CNT_W   write data; control uses [3:0]=enable,polarity,align(1=centre),oneshot
//  sync_start  in   1       pulse: every enabled channel's counter forced to 0 next edge
//  pwm_out     out  NUM_CH  registered PWM outputs
//  period_end  out  NUM_CH  registered 1-cycle pulse per completed period
//  ch_enabled  out  NUM_CH  current enable bit per channel (reflects one-shot auto-clear)
// BEHAVIOUR
//  - Reset: all control/shadow/active/count regs = 0, pending flags = 0; pwm_out, period_end, ch_enabled = 0.
//    rst asserted mid-period wins over every other input on that edge.
//  - Control write: takes effect next edge. 0->1 enable starts count at 0; 1->0 clears count to 0.
//    polarity/align changes while running apply immediately (no shadowing).
//  - Period/duty write while channel disabled: loads shadow AND active directly, pending stays 0.
//  - Period/duty write while enabled: loads shadow, sets that field's pending flag.
//  - Counter: counts 0..P-1 (P = active period); at count==P-1: count->0, period_end pulse, every
//    pending field copies shadow->active, pending clears. Write on same edge as rollover: active takes
//    the pre-write shadow only if already pending; new value becomes pending for the next boundary.
//  - P==0 while enabled: count held 0, no period_end, output inactive; pending shadows load next edge.
//  - sync_start: count->0 on enabled channels, no period_end, no shadow load; coincident rollover
//    suppressed. sync_start with an enabling control write: channel starts at 0 (same result).
//  - Level (D = min(active duty, P)): edge: high = count < D.
//    centre: S = (P>>1)-(D>>1); high = S <= count < S+D; compute in CNT_W+1 bits, no wrap.
//    D==0 -> never high; D>=P -> high all period.
//  - pwm_out (registered): enabled -> high ^ polarity; disabled -> polarity (idle = inactive level).
//    Latency: count value in cycle t is reflected on pwm_out at t+1; period_end aligned the same way.
//  - One-shot: at first rollover after enable, enable bit auto-clears (ch_enabled drops on same edge
//    as period_end pulse); output returns to idle. Control write on that edge overrides the auto-clear.
//  - Channels fully independent except shared write port and sync_start.
// TESTING
//  - Reset: drive rst 1 cycle mid-run -> pwm_out/period_end/ch_enabled = 0 next edge, counts restart at 0.
//  - Edge ch0: P=10,D=3,pol=0,en -> pwm_out high 3 of 10 cycles, period_end every 10 cycles;
//    D=0 -> constant 0; D=12 -> constant 1; pol=1 -> inverted, idle 1 when disabled.
//  - Centre ch1: P=10,D=4 -> high for counts 3..6; P=10,D=5 -> high counts 3..7; symmetric about P/2.
//  - Shadow: running P=10,D=3, write D=7 mid-period -> current period stays 3 high, next period 7 high;
//    write coincident with rollover -> applies one period later.
//  - One-shot ch2: P=8,D=2,oneshot+en -> exactly one 2-cycle pulse, one period_end, ch_enabled 1->0.
//  - Sync: ch0 P=10, ch3 P=10 started 4 cycles apart, pulse sync_start -> both counters 0, outputs
//    in phase thereafter; write to wr_ch=NUM_CH or wr_sel=3 -> no state change.

Source files
------------

// File: rtl/pwm_multichannel.sv
// -----------------------------------------------------------------------------
// pwm_multichannel
//
// Purpose:
//    NUM_CH independent PWM channels. Each channel has a CNT_W-bit period and
//    duty, edge- or centre-aligned output, selectable polarity, one-shot mode
//    and shadowed period/duty registers. Shadow values move to the active
//    registers only at a period boundary, so no period is ever cut short or
//    stretched by a register write. A global sync strobe re-phases every
//    enabled channel's counter to zero.
//
// Ports:
//    clk         in   1        system clock, rising edge
//    rst         in   1        synchronous, active-high reset
//    wr_en       in   1        register write strobe (one write per cycle)
//    wr_ch       in   CH_W     target channel; values >= NUM_CH are ignored
//    wr_sel      in   2        0 = control, 1 = period, 2 = duty, 3 = reserved
//    wr_data     in   CNT_W    write data; control layout is
//                              [3] enable, [2] polarity, [1] align (1 = centre),
//                              [0] one-shot
//    sync_start  in   1        pulse: enabled counters forced to 0 next edge
//    pwm_out     out  NUM_CH   registered PWM outputs
//    period_end  out  NUM_CH   registered 1-cycle pulse per completed period
//    ch_enabled  out  NUM_CH   current enable bit (drops on one-shot auto-clear)
//
// Timing:
//    The counter value held during cycle t is reflected on pwm_out at t+1;
//    period_end is aligned the same way (it pulses together with the output
//    sample of the last count of the period).
// -----------------------------------------------------------------------------
module pwm_multichannel #(
   parameter  int NUM_CH = 4,
   parameter  int CNT_W  = 16,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [1:0]        wr_sel,
   input  logic [CNT_W-1:0]  wr_data,
   input  logic              sync_start,
   output logic [NUM_CH-1:0] pwm_out,
   output logic [NUM_CH-1:0] period_end,
   output logic [NUM_CH-1:0] ch_enabled
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [1:0]       SEL_CTRL = 2'd0;
   localparam logic [1:0]       SEL_PER  = 2'd1;
   localparam logic [1:0]       SEL_DUTY = 2'd2;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch

      // ---------------- registers ----------------
      logic             en_q,       en_d;
      logic             pol_q,      pol_d;
      logic             align_q,    align_d;
      logic             os_q,       os_d;
      logic [CNT_W-1:0] cnt_q,      cnt_d;
      logic [CNT_W-1:0] per_sh_q,   per_sh_d;
      logic [CNT_W-1:0] per_act_q,  per_act_d;
      logic             per_pend_q, per_pend_d;
      logic [CNT_W-1:0] duty_sh_q,  duty_sh_d;
      logic [CNT_W-1:0] duty_act_q, duty_act_d;
      logic             duty_pend_q, duty_pend_d;
      logic             pwm_q,      pwm_d;
      logic             pend_q,     pend_d;   // period_end flop

      // ---------------- combinational helpers ----------------
      logic             ctrl_wr_s;
      logic             per_wr_s;
      logic             duty_wr_s;
      logic             per_zero_s;
      logic             rollover_s;
      logic             load_s;
      logic [CNT_W:0]   per_x_s;
      logic [CNT_W:0]   duty_x_s;
      logic [CNT_W:0]   cnt_x_s;
      logic [CNT_W:0]   dclip_s;
      logic [CNT_W:0]   start_s;
      logic [CNT_W:0]   stop_s;
      logic             high_s;

      // Decode the shared write port for this channel.
      always_comb begin
         ctrl_wr_s = 1'b0;
         per_wr_s  = 1'b0;
         duty_wr_s = 1'b0;
         if (wr_en && (wr_ch == CH_W'(g))) begin
            case (wr_sel)
               SEL_CTRL: ctrl_wr_s = 1'b1;
               SEL_PER:  per_wr_s  = 1'b1;
               SEL_DUTY: duty_wr_s = 1'b1;
               default:  ctrl_wr_s = 1'b0;   // reserved selector: no effect
            endcase
         end else begin
            ctrl_wr_s = 1'b0;
         end
      end

      // Period boundary detection and shadow-load qualification.
      always_comb begin
         per_zero_s = (per_act_q == CNT_ZERO);
         // sync_start suppresses a coincident rollover entirely.
         rollover_s = en_q && !per_zero_s && !sync_start &&
                      (cnt_q == (per_act_q - CNT_ONE));
         // Pending shadows move to active at a rollover, on every edge while
         // P==0 (there is no period to protect), and whenever the channel is
         // idle (no period in progress).
         if (!en_q) begin
            load_s = 1'b1;
         end else if (per_zero_s) begin
            load_s = !sync_start;
         end else begin
            load_s = rollover_s;
         end
      end

      // Output level from the active period/duty and current count.
      // Everything is widened by one bit so S+D can never wrap.
      always_comb begin
         per_x_s  = {1'b0, per_act_q};
         duty_x_s = {1'b0, duty_act_q};
         cnt_x_s  = {1'b0, cnt_q};
         dclip_s  = (duty_x_s > per_x_s) ? per_x_s : duty_x_s;
         start_s  = (per_x_s >> 1) - (dclip_s >> 1);
         stop_s   = start_s + dclip_s;
         if (per_zero_s) begin
            high_s = 1'b0;
         end else if (align_q) begin
            high_s = (cnt_x_s >= start_s) && (cnt_x_s < stop_s);
         end else begin
            high_s = (cnt_x_s < dclip_s);
         end
      end

      // Next-state computation for control, counter, shadows and outputs.
      always_comb begin
         en_d        = en_q;
         pol_d       = pol_q;
         align_d     = align_q;
         os_d        = os_q;
         cnt_d       = cnt_q;
         per_sh_d    = per_sh_q;
         per_act_d   = per_act_q;
         per_pend_d  = per_pend_q;
         duty_sh_d   = duty_sh_q;
         duty_act_d  = duty_act_q;
         duty_pend_d = duty_pend_q;

         // Control: an explicit write always beats the one-shot auto-clear.
         if (ctrl_wr_s) begin
            en_d    = wr_data[3];
            pol_d   = wr_data[2];
            align_d = wr_data[1];
            os_d    = wr_data[0];
         end else if (rollover_s && os_q) begin
            en_d = 1'b0;
         end else begin
            en_d = en_q;
         end

         // Counter: enabling starts from 0 because a disabled counter is
         // held at 0; disabling clears it.
         if (ctrl_wr_s && !wr_data[3]) begin
            cnt_d = CNT_ZERO;
         end else if (!en_q || sync_start || per_zero_s || rollover_s) begin
            cnt_d = CNT_ZERO;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end

         // Period field. The boundary load uses the pre-write shadow, then a
         // write on the same edge becomes pending for the next boundary.
         if (per_wr_s && !en_q) begin
            per_sh_d   = wr_data;
            per_act_d  = wr_data;
            per_pend_d = 1'b0;
         end else if (per_wr_s) begin
            per_sh_d   = wr_data;
            per_act_d  = (load_s && per_pend_q) ? per_sh_q : per_act_q;
            per_pend_d = 1'b1;
         end else if (load_s && per_pend_q) begin
            per_act_d  = per_sh_q;
            per_pend_d = 1'b0;
         end else begin
            per_act_d  = per_act_q;
         end

         // Duty field, same rules as the period field.
         if (duty_wr_s && !en_q) begin
            duty_sh_d   = wr_data;
            duty_act_d  = wr_data;
            duty_pend_d = 1'b0;
         end else if (duty_wr_s) begin
            duty_sh_d   = wr_data;
            duty_act_d  = (load_s && duty_pend_q) ? duty_sh_q : duty_act_q;
            duty_pend_d = 1'b1;
         end else if (load_s && duty_pend_q) begin
            duty_act_d  = duty_sh_q;
            duty_pend_d = 1'b0;
         end else begin
            duty_act_d  = duty_act_q;
         end

         // Idle level of a disabled channel is the inactive level, i.e. the
         // polarity bit itself.
         if (en_q) begin
            pwm_d = high_s ^ pol_q;
         end else begin
            pwm_d = pol_q;
         end
         pend_d = rollover_s;
      end

      // Channel state registers with synchronous reset.
      always_ff @(posedge clk) begin
         if (rst) begin
            en_q        <= 1'b0;
            pol_q       <= 1'b0;
            align_q     <= 1'b0;
            os_q        <= 1'b0;
            cnt_q       <= CNT_ZERO;
            per_sh_q    <= CNT_ZERO;
            per_act_q   <= CNT_ZERO;
            per_pend_q  <= 1'b0;
            duty_sh_q   <= CNT_ZERO;
            duty_act_q  <= CNT_ZERO;
            duty_pend_q <= 1'b0;
            pwm_q       <= 1'b0;
            pend_q      <= 1'b0;
         end else begin
            en_q        <= en_d;
            pol_q       <= pol_d;
            align_q     <= align_d;
            os_q        <= os_d;
            cnt_q       <= cnt_d;
            per_sh_q    <= per_sh_d;
            per_act_q   <= per_act_d;
            per_pend_q  <= per_pend_d;
            duty_sh_q   <= duty_sh_d;
            duty_act_q  <= duty_act_d;
            duty_pend_q <= duty_pend_d;
            pwm_q       <= pwm_d;
            pend_q      <= pend_d;
         end
      end

      assign pwm_out[g]    = pwm_q;
      assign period_end[g] = pend_q;
      assign ch_enabled[g] = en_q;

   end : g_ch

endmodule
